hq_scheduler: RTL and testbench

HQ_SCHEDULER -- requirements
Module: hq_scheduler

---
 rtl/mm_pkg.sv | 31 +++
 rtl/hq_out_fifo.sv | 51 +++++
 rtl/hq_scheduler.sv | 191 +++++++++++++++++++
 tb/tb_hq_scheduler.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mm_pkg.sv
// Shared constants and types for the H*q scheduler and its output FIFO.
package mm_pkg;
  localparam int N          = 16;  // signed Q8.8 sample width
  localparam int ROWS       = 4;
  localparam int COLS       = 4;
  localparam int NQ_MAX     = 16;
  localparam int HQ_BEATS   = 8;   // result beats returned per q index
  localparam int FIFO_DEPTH = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ISSUE,
    ST_FEED,
    ST_COLLECT,
    ST_DRAIN,
    ST_FIN
  } state_t;

  typedef struct packed {
    logic signed [N-1:0] r;
    logic signed [N-1:0] i;
  } cplx_t;

  typedef struct packed {
    logic [3:0] q;
    logic [2:0] idx;
    logic       last;
    cplx_t      s;
  } out_beat_t;
endpackage

// File: rtl/hq_out_fifo.sv
// 8-deep synchronous FIFO holding tagged result beats; head entry is always
// visible on o_dout, so a pushed beat appears one cycle after the push.
module hq_out_fifo
  import mm_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      i_push,
  input  out_beat_t i_din,
  input  logic      i_pop,
  output out_beat_t o_dout,
  output logic      o_empty,
  output logic      o_full
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  out_beat_t     r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == FULL_CNT);
  assign o_dout    = r_mem[r_rd_ptr];

  // Storage, pointers and occupancy; storage clears on reset so the head reads zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < FIFO_DEPTH; k++) r_mem[k] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_din;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/hq_scheduler.sv
// Loads a 4x4 complex H, then for each q index starts the matrix multiplier,
// replays H to it, and forwards its 8 result beats through a tagged FIFO.
// Output handshake: a beat moves only on a cycle where out_valid && out_ready;
// while out_valid is high and out_ready low, every out_* signal holds its value.
module hq_scheduler
  import mm_pkg::*;
#(
  parameter int N      = mm_pkg::N,
  parameter int ROWS   = mm_pkg::ROWS,
  parameter int COLS   = mm_pkg::COLS,
  parameter int NQ_MAX = mm_pkg::NQ_MAX
)(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [4:0]   num_q,
  input  logic         H_in_valid,
  input  logic [N-1:0] H_in_r,
  input  logic [N-1:0] H_in_i,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic         mm_start,
  output logic [3:0]   mm_q_index,
  output logic         mm_H_valid,
  output logic [N-1:0] mm_H_r,
  output logic [N-1:0] mm_H_i,
  input  logic         mm_done,
  input  logic         mm_Hq_valid,
  input  logic [N-1:0] mm_Hq_r,
  input  logic [N-1:0] mm_Hq_i,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [3:0]   out_q,
  output logic [2:0]   out_idx,
  output logic [N-1:0] out_r,
  output logic [N-1:0] out_i,
  output logic         out_last
);
  localparam int H_DEPTH = ROWS * COLS;
  localparam int HW      = $clog2(H_DEPTH);
  localparam int QW      = $clog2(NQ_MAX + 1);
  localparam logic [HW-1:0] H_LAST     = HW'(H_DEPTH - 1);
  localparam logic [3:0]    BEATS_FULL = 4'(HQ_BEATS);

  state_t        r_state;
  state_t        w_next_state;
  logic [HW-1:0] r_h_cnt;    // LOAD write address, then FEED read address
  logic [3:0]    r_beat;     // result beats accepted for the current q
  logic [QW-1:0] r_num_q;
  logic [QW-1:0] r_q;
  logic          r_err;
  cplx_t         r_hbuf [H_DEPTH];

  logic          w_beat_accept;
  logic [3:0]    w_beats_rcvd;
  logic          w_last;
  logic          w_fifo_push;
  logic          w_fifo_pop;
  logic          w_fifo_empty;
  logic          w_fifo_full;
  out_beat_t     w_push_beat;
  out_beat_t     w_fifo_dout;

  assign w_beat_accept = mm_Hq_valid && (r_beat != BEATS_FULL) && !w_fifo_full;
  assign w_beats_rcvd  = r_beat + {3'b000, w_beat_accept};
  assign w_last        = (r_beat == 4'd7) && (r_q == r_num_q - 1'b1);
  assign w_push_beat   = {r_q[3:0], r_beat[2:0], w_last, mm_Hq_r, mm_Hq_i};

  assign err        = r_err;
  assign mm_q_index = r_q[3:0];
  assign mm_H_r     = (r_state == ST_FEED) ? r_hbuf[r_h_cnt].r : '0;
  assign mm_H_i     = (r_state == ST_FEED) ? r_hbuf[r_h_cnt].i : '0;

  assign out_valid  = !w_fifo_empty;
  assign w_fifo_pop = out_valid && out_ready;
  assign out_q      = w_fifo_dout.q;
  assign out_idx    = w_fifo_dout.idx;
  assign out_last   = w_fifo_dout.last;
  assign out_r      = w_fifo_dout.s.r;
  assign out_i      = w_fifo_dout.s.i;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state decode and per-state control outputs.
  always_comb begin
    w_next_state = r_state;
    busy         = 1'b1;
    done         = 1'b0;
    mm_start     = 1'b0;
    mm_H_valid   = 1'b0;
    w_fifo_push  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) w_next_state = ST_LOAD;
      end
      ST_LOAD: begin
        if (H_in_valid && (r_h_cnt == H_LAST))
          w_next_state = (r_num_q == '0) ? ST_FIN : ST_ISSUE;
      end
      ST_ISSUE: begin
        // Only one q's results may sit in the FIFO at a time.
        if (w_fifo_empty) begin
          mm_start     = 1'b1;
          w_next_state = ST_FEED;
        end
      end
      ST_FEED: begin
        mm_H_valid = 1'b1;
        if (r_h_cnt == H_LAST) w_next_state = ST_COLLECT;
      end
      ST_COLLECT: begin
        w_fifo_push = w_beat_accept;
        if (mm_done) w_next_state = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (r_q != r_num_q)   w_next_state = ST_ISSUE;
        else if (w_fifo_empty) w_next_state = ST_FIN;
      end
      ST_FIN: begin
        done         = 1'b1;
        w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Job counters and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h_cnt <= '0;
      r_beat  <= '0;
      r_num_q <= '0;
      r_q     <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_num_q <= num_q;
            r_q     <= '0;
            r_err   <= 1'b0;
            r_h_cnt <= '0;
          end
        end
        ST_LOAD: begin
          if (H_in_valid) r_h_cnt <= (r_h_cnt == H_LAST) ? '0 : r_h_cnt + 1'b1;
        end
        ST_ISSUE: begin
          if (w_fifo_empty) begin
            r_h_cnt <= '0;
            r_beat  <= '0;
          end
        end
        ST_FEED: begin
          r_h_cnt <= (r_h_cnt == H_LAST) ? '0 : r_h_cnt + 1'b1;
        end
        ST_COLLECT: begin
          if (w_beat_accept) r_beat <= r_beat + 1'b1;
          else if (mm_Hq_valid) r_err <= 1'b1;   // beat beyond the eighth is dropped
          if (mm_done) begin
            if (w_beats_rcvd < BEATS_FULL) r_err <= 1'b1;
            r_q <= r_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // H buffer; written only while loading so it survives every q pass.
  always_ff @(posedge clk) begin
    if ((r_state == ST_LOAD) && H_in_valid) r_hbuf[r_h_cnt] <= {H_in_r, H_in_i};
  end

  hq_out_fifo u_out_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_fifo_push),
    .i_din   (w_push_beat),
    .i_pop   (w_fifo_pop),
    .o_dout  (w_fifo_dout),
    .o_empty (w_fifo_empty),
    .o_full  (w_fifo_full)
  );
endmodule

// File: tb/tb_hq_scheduler.sv
// Bench for hq_scheduler: a matrix-multiplier stand-in answers each mm_start,
// and every forwarded beat is matched against an expected queue.
module tb_hq_scheduler;
  localparam int W = 40;  // {q[3:0], idx[2:0], last, r[15:0], i[15:0]}

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [4:0]  num_q;
  logic        H_in_valid;
  logic [15:0] H_in_r, H_in_i;
  logic        busy, done, err;
  logic        mm_start, mm_H_valid;
  logic [3:0]  mm_q_index;
  logic [15:0] mm_H_r, mm_H_i;
  logic        mm_done, mm_Hq_valid;
  logic [15:0] mm_Hq_r, mm_Hq_i;
  logic        out_valid, out_ready, out_last;
  logic [3:0]  out_q;
  logic [2:0]  out_idx;
  logic [15:0] out_r, out_i;

  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];
  logic [15:0]  h_r [16];
  logic [15:0]  h_i [16];
  int mm_beats = 8;
  int cur_num_q = 0;
  int job_starts = 0;
  int out_count = 0;
  int done_cnt = 0;

  hq_scheduler dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_q(num_q),
    .H_in_valid(H_in_valid), .H_in_r(H_in_r), .H_in_i(H_in_i),
    .busy(busy), .done(done), .err(err),
    .mm_start(mm_start), .mm_q_index(mm_q_index), .mm_H_valid(mm_H_valid),
    .mm_H_r(mm_H_r), .mm_H_i(mm_H_i),
    .mm_done(mm_done), .mm_Hq_valid(mm_Hq_valid), .mm_Hq_r(mm_Hq_r), .mm_Hq_i(mm_Hq_i),
    .out_valid(out_valid), .out_ready(out_ready), .out_q(out_q), .out_idx(out_idx),
    .out_r(out_r), .out_i(out_i), .out_last(out_last)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Matrix-multiplier stand-in: checks the H replay, returns mm_beats results.
  initial begin : mm_model
    int qi;
    bit aborted;
    logic [W-1:0] e;
    mm_done = 0; mm_Hq_valid = 0; mm_Hq_r = 0; mm_Hq_i = 0;
    forever begin
      @(negedge clk);
      if (rst_n && mm_start) begin
        qi = job_starts;
        check("mm_q_index", mm_q_index, qi);
        check("fifo_empty_at_mm_start", out_valid, 0);
        job_starts++;
        aborted = 0;
        for (int k = 0; k < 16; k++) begin
          @(negedge clk);
          if (!rst_n) begin aborted = 1; break; end
          check("mm_H_valid", mm_H_valid, 1);
          check("mm_H_r", mm_H_r, h_r[k]);
          check("mm_H_i", mm_H_i, h_i[k]);
        end
        if (!aborted) begin
          @(posedge clk); #1;
          for (int b = 0; b < mm_beats; b++) begin
            mm_Hq_valid = 1;
            mm_Hq_r = 16'($urandom);
            mm_Hq_i = 16'($urandom);
            if (b < 8) begin
              e = {qi[3:0], b[2:0], (b == 7 && qi == cur_num_q - 1), mm_Hq_r, mm_Hq_i};
              exp_q.push_back(e);
            end
            @(posedge clk); #1;
          end
          mm_Hq_valid = 0;
          mm_done = 1;
          @(posedge clk); #1;
          mm_done = 0;
        end
      end
    end
  end

  // Output scoreboard, stall-stability check and done counter.
  initial begin : out_monitor
    bit prev_stall;
    logic [W-1:0] prev_beat, cur, e;
    prev_stall = 0;
    prev_beat = '0;
    forever begin
      @(negedge clk);
      cur = {out_q, out_idx, out_last, out_r, out_i};
      if (rst_n && out_valid) begin
        if (prev_stall) check("out_stable", cur, prev_beat);
        if (out_ready) begin
          if (exp_q.size() == 0) check("unexpected_out", cur, '0);
          else begin
            e = exp_q.pop_front();
            check("out_beat", cur, e);
            out_count++;
          end
        end
      end
      prev_stall = rst_n && out_valid && !out_ready;
      prev_beat = cur;
      if (rst_n && done) done_cnt++;
    end
  end

  // Driver: one job from load to done (or to a mid-FEED reset of q 1).
  task automatic run_job(input int nq, input int beats, input bit ident,
                         input int stall, input bit bp, input bit do_rst);
    int seen, oc0, d0, rst_cnt, gap, exp_beats;
    bit got_done, did_rst, exp_err;
    mm_beats = beats;
    cur_num_q = nq;
    job_starts = 0;
    for (int k = 0; k < 16; k++) begin
      if (ident) begin
        h_r[k] = (k % 5 == 0) ? 16'h0100 : 16'h0000;
        h_i[k] = 16'h0000;
      end else begin
        h_r[k] = 16'($urandom);
        h_i[k] = 16'($urandom);
      end
    end
    oc0 = out_count;
    out_ready = (stall > 0) ? 1'b0 : 1'b1;
    // stray beat while idle must not reach the buffer
    H_in_valid = 1; H_in_r = 16'hdead; H_in_i = 16'hbeef;
    @(posedge clk); #1;
    H_in_valid = 0;
    num_q = 5'(nq);
    start = 1;
    @(posedge clk); #1;
    start = 0;
    check("busy_after_start", busy, 1);
    check("err_clear_on_start", err, 0);
    // a start while loading must be ignored
    start = 1; num_q = 5'd7;
    @(posedge clk); #1;
    start = 0; num_q = 0;
    for (int k = 0; k < 16; k++) begin
      gap = $urandom_range(0, 2);
      repeat (gap) begin @(posedge clk); #1; end
      H_in_valid = 1; H_in_r = h_r[k]; H_in_i = h_i[k];
      @(posedge clk); #1;
      H_in_valid = 0;
    end
    got_done = done;
    H_in_valid = 1; H_in_r = 16'h1234; H_in_i = 16'h5678;  // ignored outside LOAD
    did_rst = 0; seen = 0; rst_cnt = 0;
    if (!got_done) begin
      for (int c = 0; c < 3000; c++) begin
        @(posedge clk); #1;
        H_in_valid = 0;
        if (done) begin got_done = 1; break; end
        if (out_valid) seen++;
        if (stall > 0) out_ready = (seen > stall);
        else if (bp) out_ready = ($urandom_range(0, 3) != 0);
        else out_ready = 1;
        if (do_rst && job_starts == 2) begin
          rst_cnt++;
          if (rst_cnt == 5) begin did_rst = 1; break; end
        end
      end
    end
    H_in_valid = 0;
    if (do_rst) begin
      check("rst_reached_feed_q1", did_rst, 1);
      check("rst_in_feed", mm_H_valid, 1);
      rst_n = 0;
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_mm_start", mm_start, 0);
      check("rst_mm_q_index", mm_q_index, 0);
      check("rst_mm_H_valid", mm_H_valid, 0);
      check("rst_mm_H", {mm_H_r, mm_H_i}, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_fields", {out_q, out_idx, out_last, out_r, out_i}, 0);
      exp_q.delete();
      repeat (3) @(posedge clk);
      #1 rst_n = 1;
      d0 = done_cnt;
      repeat (30) @(posedge clk);
      #1;
      check("no_done_after_rst", done_cnt - d0, 0);
      check("idle_after_rst", busy, 0);
    end else begin
      exp_beats = nq * ((beats < 8) ? beats : 8);
      exp_err = (nq > 0) && (beats != 8);
      check("done_seen", got_done, 1);
      check("mm_start_count", job_starts, nq);
      check("out_beat_count", out_count - oc0, exp_beats);
      check("exp_q_empty", exp_q.size(), 0);
      check("err_at_done", err, exp_err);
      @(posedge clk); #1;
      check("done_one_cycle", done, 0);
      check("busy_idle", busy, 0);
      check("err_sticky", err, exp_err);
    end
    out_ready = 1;
  endtask

  initial begin : main
    rst_n = 0; start = 0; num_q = 0;
    H_in_valid = 0; H_in_r = 0; H_in_i = 0; out_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_err", err, 0);
    check("reset_mm_start", mm_start, 0);
    check("reset_mm_q_index", mm_q_index, 0);
    check("reset_mm_H", {mm_H_valid, mm_H_r, mm_H_i}, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_fields", {out_q, out_idx, out_last, out_r, out_i}, 0);
    rst_n = 1;
    @(posedge clk); #1;

    run_job(1, 8, 1, 0, 0, 0);   // identity H, single q
    run_job(3, 8, 0, 0, 0, 0);   // three q passes, same H each time
    run_job(2, 8, 0, 20, 0, 0);  // consumer stalls during q 0
    run_job(0, 8, 0, 0, 0, 0);   // no q indices
    run_job(1, 9, 0, 0, 0, 0);   // one beat too many
    run_job(1, 7, 0, 0, 0, 0);   // one beat short
    run_job(3, 8, 0, 0, 0, 1);   // reset during FEED of q 1
    run_job(2, 8, 0, 0, 1, 0);   // recovery after reset
    for (int t = 0; t < 4; t++) run_job($urandom_range(0, 4), 8, 0, 0, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
